conv_mac_pipe: RTL and testbench
================================

CONV_MAC_PIPE -- requirements
Module: conv_mac_pipe

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- FILTER_SIZE, 5, kernel side length; N = FILTER_SIZE*FILTER_SIZE.
- DATA_BITS, 8, signed width of data, weight, bias and output.
- IN_CH, 3, input-channel beats accumulated per output (≥1).
- OUT_CH, 3, output channels computed in parallel.
- SHIFT_NUM, 16, arithmetic right-shift applied to the accumulator (≥1).
- ACC_BITS, 32, signed accumulator width.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_val, in, 1, input beat valid.
- in_rdy, out, 1, input beat ready.
- data_in, in, N*DATA_BITS, signed window; element i at [i*DATA_BITS +: DATA_BITS].
- weight, in, OUT_CH*N*DATA_BITS, signed weights for the current input channel; element (k,i) at [(k*N+i)*DATA_BITS +: DATA_BITS].
- bias, in, OUT_CH*DATA_BITS, signed bias per output channel; sampled with the last beat.
- data_out, out, OUT_CH*DATA_BITS, signed result per output channel.
- out_val, out, 1, result valid.
- out_rdy, in, 1, downstream ready.

Function
REQ-003 A beat SHALL be accepted on a rising edge where in_val=1 and in_rdy=1.
REQ-004 in_rdy SHALL be decoded from the state register only, with no combinational path from in_val or out_rdy.
REQ-005 The FSM SHALL have three states:
- ACCUM: in_rdy=1, out_val=0.
- DRAIN: in_rdy=0, out_val=0.
- OUTPUT: in_rdy=0, out_val=1.
REQ-006 FSM transitions SHALL be:
- ACCUM→DRAIN on acceptance of beat number IN_CH-1.
- DRAIN→OUTPUT when that beat's contribution is written into data_out.
- OUTPUT→ACCUM on out_val&&out_rdy.
- All other cases hold the current state.
REQ-007 A beat counter SHALL count 0..IN_CH-1, increment per accepted beat and wrap to 0 on the last beat; with IN_CH=1 every beat is last.
REQ-008 Stage P: on acceptance, the block SHALL register OUT_CH×N full-precision (2*DATA_BITS) signed products, a first-beat flag, a last-beat flag and, on the last beat only, the bias.
REQ-009 Stage A: one cycle after stage P, the block SHALL sum each channel's N products sign-extended to ACC_BITS and either load the accumulator (first beat) or add to it.
REQ-010 On the last beat, stage A SHALL form the result as:
- r = ((acc_total + 2^(SHIFT_NUM-1)) >>> SHIFT_NUM) + bias, i.e. round half up;
- saturate r to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1];
- register r into data_out.
REQ-011 Latency SHALL be 2 cycles: last beat accepted at edge t gives out_val=1 after edge t+2.
REQ-012 data_out SHALL hold stable while out_val=1 and out_rdy=0, for any number of cycles.
REQ-013 After the output handshake, in_rdy SHALL be 1 on the following cycle; no beat is accepted in the handshake cycle itself.
REQ-014 Accumulator overflow beyond ACC_BITS SHALL wrap (two's complement); saturation applies only at REQ-010.

Reset
REQ-015 When rst_n=0, the block SHALL asynchronously set state=ACCUM, beat counter=0, pipeline flags=0, accumulator=0, data_out=0 and out_val=0; in_rdy reads 1 during and after reset.
REQ-016 Reset asserted mid-accumulation or mid-OUTPUT SHALL discard all partial results; the first beat after release is treated as beat 0.

Configuration
REQ-017 With macro CONV_MAC_RELU_EN defined, the saturated result SHALL be clamped to 0 when negative before registering into data_out.
REQ-018 With CONV_MAC_RELU_EN undefined, negative saturated results SHALL pass through unchanged.

Verification
REQ-019 The bench SHALL cover these directed scenarios, each stated as stimulus → required response:
- Reset: IN_CH=1; all data=1, all weights=127, bias=0, SHIFT_NUM=0 excluded; with SHIFT_NUM=1 → 25*127=3175 → rounded 1588 → saturated to 127 on every channel, out_val after exactly 2 cycles.
- Accumulation: IN_CH=3, SHIFT_NUM=16, data=64, weights=64 per beat, bias=-5 → sum=3*25*4096=307200, rounded 307200/65536 = 4.6875 → 5, output 0 on each channel.
- Negative path: data=-128, weights=127, IN_CH=1, SHIFT_NUM=4, bias=0 → output -128 without macro, 0 with CONV_MAC_RELU_EN.
- Backpressure: out_rdy=0 for 10 cycles with in_val=1 held → in_rdy=0 throughout, data_out stable, no beat lost; handshake → in_rdy=1 next cycle.
- Reset mid-operation: rst_n pulse after beat 1 of 3 → next 3 beats produce a result equal to a clean run.
- Back-to-back: continuous in_val with out_rdy=1 → one result per IN_CH+3 cycles, beat counter wraps correctly.

Source files
------------

// File: rtl/conv_mac_pipe_if.sv
// rtl/conv_mac_pipe_if.sv - beat/result handshake bundle for conv_mac_pipe
interface conv_mac_pipe_if #(
  parameter int FILTER_SIZE = 5,
  parameter int DATA_BITS   = 8,
  parameter int OUT_CH      = 3
);
  localparam int N = FILTER_SIZE * FILTER_SIZE;

  logic                            in_val;
  logic                            in_rdy;
  logic [N*DATA_BITS-1:0]          data_in;
  logic [OUT_CH*N*DATA_BITS-1:0]   weight;
  logic [OUT_CH*DATA_BITS-1:0]     bias;
  logic [OUT_CH*DATA_BITS-1:0]     data_out;
  logic                            out_val;
  logic                            out_rdy;

  modport master (
    output in_val, data_in, weight, bias, out_rdy,
    input  in_rdy, data_out, out_val
  );

  modport slave (
    input  in_val, data_in, weight, bias, out_rdy,
    output in_rdy, data_out, out_val
  );
endinterface

// File: rtl/conv_mac_pipe.sv
// rtl/conv_mac_pipe.sv - multi-channel conv MAC: product stage, accumulate/round/saturate stage
// Optional macro CONV_MAC_RELU_EN clamps negative results to zero.
module conv_mac_pipe #(
  parameter int FILTER_SIZE = 5,
  parameter int DATA_BITS   = 8,
  parameter int IN_CH       = 3,
  parameter int OUT_CH      = 3,
  parameter int SHIFT_NUM   = 16,
  parameter int ACC_BITS    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  conv_mac_pipe_if.slave bus
);
  localparam int N         = FILTER_SIZE * FILTER_SIZE;
  localparam int PROD_BITS = 2 * DATA_BITS;
  localparam int CNT_W     = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int RND_BITS  = ACC_BITS + 1;
  localparam int R_BITS    = ACC_BITS + 2;

  localparam logic [CNT_W-1:0]           LAST_CNT = CNT_W'(IN_CH - 1);
  localparam logic signed [RND_BITS-1:0] RND      = RND_BITS'(1) <<< (SHIFT_NUM - 1);
  localparam logic signed [R_BITS-1:0]   OUT_MAX  = R_BITS'((2 ** (DATA_BITS - 1)) - 1);
  localparam logic signed [R_BITS-1:0]   OUT_MIN  = R_BITS'(-(2 ** (DATA_BITS - 1)));

`ifdef CONV_MAC_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   in_rdy_c, out_val_c;

  logic [CNT_W-1:0] beat_cnt_q;
  logic             accept, last_beat;

  logic signed [PROD_BITS-1:0]    prod_q [OUT_CH][N];
  logic [OUT_CH*DATA_BITS-1:0]    p_bias_q;
  logic                           p_valid_q, p_first_q, p_last_q;
  logic                           a_done_q;

  logic signed [ACC_BITS-1:0]     acc_q     [OUT_CH];
  logic signed [ACC_BITS-1:0]     sum_c     [OUT_CH];
  logic signed [ACC_BITS-1:0]     acc_tot_c [OUT_CH];
  logic signed [RND_BITS-1:0]     rnd_c     [OUT_CH];
  logic signed [RND_BITS-1:0]     sh_c      [OUT_CH];
  logic signed [R_BITS-1:0]       r_c       [OUT_CH];
  logic signed [R_BITS-1:0]       sat_c     [OUT_CH];
  logic [OUT_CH*DATA_BITS-1:0]    res_c;
  logic [OUT_CH*DATA_BITS-1:0]    data_out_q;

  assign accept    = bus.in_val && in_rdy_c;
  assign last_beat = (beat_cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // in_rdy/out_val depend on state_q only, never on in_val or out_rdy
  always_comb begin
    state_d   = state_q;
    in_rdy_c  = 1'b0;
    out_val_c = 1'b0;
    case (state_q)
      ACCUM: begin
        in_rdy_c = 1'b1;
        if (bus.in_val && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (a_done_q) state_d = OUTPUT;
      end
      OUTPUT: begin
        out_val_c = 1'b1;
        if (bus.out_rdy) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign bus.in_rdy   = in_rdy_c;
  assign bus.out_val  = out_val_c;
  assign bus.data_out = data_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (accept) begin
      beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
    end
  end

  // Stage P datapath: no reset needed, qualified by p_valid_q downstream
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < OUT_CH; k++) begin
        for (int i = 0; i < N; i++) begin
          prod_q[k][i] <= PROD_BITS'($signed(bus.data_in[i*DATA_BITS +: DATA_BITS])) *
                          PROD_BITS'($signed(bus.weight[(k*N+i)*DATA_BITS +: DATA_BITS]));
        end
      end
      if (last_beat) p_bias_q <= bus.bias;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      p_valid_q <= accept;
      p_first_q <= accept && (beat_cnt_q == '0);
      p_last_q  <= accept && last_beat;
    end
  end

  always_comb begin
    res_c = '0;
    for (int k = 0; k < OUT_CH; k++) begin
      sum_c[k] = '0;
      for (int i = 0; i < N; i++) begin
        sum_c[k] = sum_c[k] + ACC_BITS'(prod_q[k][i]);
      end
      acc_tot_c[k] = p_first_q ? sum_c[k] : acc_q[k] + sum_c[k];
      // one extra bit so the rounding offset cannot wrap the total
      rnd_c[k] = RND_BITS'(acc_tot_c[k]) + RND;
      sh_c[k]  = rnd_c[k] >>> SHIFT_NUM;
      r_c[k]   = R_BITS'(sh_c[k]) + R_BITS'($signed(p_bias_q[k*DATA_BITS +: DATA_BITS]));
      if (r_c[k] > OUT_MAX)      sat_c[k] = OUT_MAX;
      else if (r_c[k] < OUT_MIN) sat_c[k] = OUT_MIN;
      else                       sat_c[k] = r_c[k];
      if (RELU_EN && sat_c[k][R_BITS-1]) sat_c[k] = '0;
      res_c[k*DATA_BITS +: DATA_BITS] = sat_c[k][DATA_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OUT_CH; k++) acc_q[k] <= '0;
      data_out_q <= '0;
      a_done_q   <= 1'b0;
    end else begin
      a_done_q <= p_valid_q && p_last_q;
      if (p_valid_q) begin
        for (int k = 0; k < OUT_CH; k++) acc_q[k] <= acc_tot_c[k];
        if (p_last_q) data_out_q <= res_c;
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb/tb_conv_mac_pipe.sv - directed scoreboard bench for conv_mac_pipe (three parameter sets)
module tb_conv_mac_pipe;
  localparam int N  = 25;
  localparam int DB = 8;
  localparam int OC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  conv_mac_pipe_if #(.FILTER_SIZE(5), .DATA_BITS(DB), .OUT_CH(OC)) ia ();
  conv_mac_pipe_if #(.FILTER_SIZE(5), .DATA_BITS(DB), .OUT_CH(OC)) ib ();
  conv_mac_pipe_if #(.FILTER_SIZE(5), .DATA_BITS(DB), .OUT_CH(OC)) ic ();

  conv_mac_pipe #(.FILTER_SIZE(5), .DATA_BITS(DB), .IN_CH(1), .OUT_CH(OC), .SHIFT_NUM(1), .ACC_BITS(32))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  conv_mac_pipe #(.FILTER_SIZE(5), .DATA_BITS(DB), .IN_CH(3), .OUT_CH(OC), .SHIFT_NUM(16), .ACC_BITS(32))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  conv_mac_pipe #(.FILTER_SIZE(5), .DATA_BITS(DB), .IN_CH(1), .OUT_CH(OC), .SHIFT_NUM(4), .ACC_BITS(32))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

`ifdef CONV_MAC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  int d [N];
  int w [OC][N];
  int b [OC];
  int macc [3][OC];
  logic [OC*DB-1:0] qa [$];
  logic [OC*DB-1:0] qb [$];
  logic [OC*DB-1:0] qc [$];
  int acc_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard consumers: one pop per output handshake
  always @(negedge clk) begin
    if (ia.out_val && ia.out_rdy) begin
      if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
      else chk("a_data_out", ia.data_out, qa.pop_front());
    end
    if (ib.out_val && ib.out_rdy) begin
      if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
      else chk("b_data_out", ib.data_out, qb.pop_front());
    end
    if (ic.out_val && ic.out_rdy) begin
      if (qc.size() == 0) chk("c_unexpected_out", 1, 0);
      else chk("c_data_out", ic.data_out, qc.pop_front());
    end
  end

  task automatic fill(input int dv, input int wv, input int bv);
    for (int i = 0; i < N; i++) begin
      d[i] = dv;
      for (int k = 0; k < OC; k++) w[k][i] = wv;
    end
    for (int k = 0; k < OC; k++) b[k] = bv;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      d[i] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < OC; k++) w[k][i] = int'($urandom_range(0, 255)) - 128;
    end
    for (int k = 0; k < OC; k++) b[k] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic drive(input int sel, input logic v);
    logic [N*DB-1:0]    dv;
    logic [OC*N*DB-1:0] wv;
    logic [OC*DB-1:0]   bv;
    for (int i = 0; i < N; i++) begin
      dv[i*DB +: DB] = d[i][DB-1:0];
      for (int k = 0; k < OC; k++) wv[(k*N+i)*DB +: DB] = w[k][i][DB-1:0];
    end
    for (int k = 0; k < OC; k++) bv[k*DB +: DB] = b[k][DB-1:0];
    case (sel)
      0: begin ia.in_val = v; ia.data_in = dv; ia.weight = wv; ia.bias = bv; end
      1: begin ib.in_val = v; ib.data_in = dv; ib.weight = wv; ib.bias = bv; end
      default: begin ic.in_val = v; ic.data_in = dv; ic.weight = wv; ic.bias = bv; end
    endcase
  endtask

  function automatic logic [OC*DB-1:0] expect_out(input int sel, input int shift);
    logic [OC*DB-1:0] e;
    longint r;
    for (int k = 0; k < OC; k++) begin
      r = ((longint'(macc[sel][k]) + (longint'(1) << (shift - 1))) >>> shift) + longint'(b[k]);
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      if (RELU && r < 0) r = 0;
      e[k*DB +: DB] = r[DB-1:0];
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic beat(input int sel, input bit first, input bit last, input int shift);
    logic rdy;
    bit ok;
    ok = 1'b0;
    drive(sel, 1'b1);
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      rdy = (sel == 0) ? ia.in_rdy : (sel == 1) ? ib.in_rdy : ic.in_rdy;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    drive(sel, 1'b0);
    chk("beat_accept", ok, 1);
    acc_cyc = cyc;
    for (int k = 0; k < OC; k++) begin
      if (first) macc[sel][k] = 0;
      for (int i = 0; i < N; i++) macc[sel][k] = macc[sel][k] + d[i] * w[k][i];
    end
    if (last) begin
      case (sel)
        0: qa.push_back(expect_out(sel, shift));
        1: qb.push_back(expect_out(sel, shift));
        default: qc.push_back(expect_out(sel, shift));
      endcase
    end
  endtask

  task automatic wait_out(input int sel);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      seen = (sel == 0) ? ia.out_val : (sel == 1) ? ib.out_val : ic.out_val;
    end
    chk("out_val_timeout", seen, 1);
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 40 && (qa.size() + qb.size() + qc.size()) != 0; t++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("scoreboard_drained", qa.size() + qb.size() + qc.size(), 0);
  endtask

  task automatic run3(input int shift);
    beat(1, 1'b1, 1'b0, shift);
    beat(1, 1'b0, 1'b0, shift);
    beat(1, 1'b0, 1'b1, shift);
  endtask

  initial begin
    logic [OC*DB-1:0] held;
    int first_cyc;
    fill(0, 0, 0);
    drive(0, 1'b0); drive(1, 1'b0); drive(2, 1'b0);
    ia.out_rdy = 1'b1; ib.out_rdy = 1'b1; ic.out_rdy = 1'b1;

    #12;
    chk("in_rdy_during_reset", {ia.in_rdy, ib.in_rdy, ic.in_rdy}, 3'b111);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_a", {ia.in_rdy, ia.out_val, ia.data_out}, {1'b1, 1'b0, 24'h0});
    chk("rst_b", {ib.in_rdy, ib.out_val, ib.data_out}, {1'b1, 1'b0, 24'h0});
    chk("rst_c", {ic.in_rdy, ic.out_val, ic.data_out}, {1'b1, 1'b0, 24'h0});

    // positive saturation and two-cycle latency
    fill(1, 127, 0);
    beat(0, 1'b1, 1'b1, 1);
    chk("lat_t0_out_val", ia.out_val, 0);
    @(posedge clk); #1;
    chk("lat_t1_out_val", ia.out_val, 0);
    @(posedge clk); #1;
    chk("lat_t2_out_val", ia.out_val, 1);
    chk("sat_pos_value", ia.data_out, 24'h7f7f7f);
    wait_empty();

    // three-beat accumulation with rounding and negative bias
    fill(64, 64, -5);
    run3(16);
    wait_out(1);
    chk("accum_value", ib.data_out, 24'h000000);
    wait_empty();

    // negative saturation, optionally clamped
    fill(-128, 127, 0);
    beat(2, 1'b1, 1'b1, 4);
    wait_out(2);
    chk("neg_value", ic.data_out, RELU ? 24'h000000 : 24'h808080);
    wait_empty();

    // backpressure: result held, next beat waits
    fill_rand();
    run3(16);
    ib.out_rdy = 1'b0;
    wait_out(1);
    held = ib.data_out;
    fill_rand();
    drive(1, 1'b1);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_in_rdy_low", ib.in_rdy, 0);
      chk("bp_out_val_high", ib.out_val, 1);
      chk("bp_data_stable", ib.data_out, held);
    end
    @(posedge clk); #1;
    ib.out_rdy = 1'b1;
    @(negedge clk);
    chk("hs_cycle_in_rdy", ib.in_rdy, 0);
    @(posedge clk); #1;
    chk("after_hs_in_rdy", ib.in_rdy, 1);
    run3(16);
    wait_empty();

    // reset after two of three beats discards partial sum
    fill_rand();
    beat(1, 1'b1, 1'b0, 16);
    beat(1, 1'b0, 1'b0, 16);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {ib.in_rdy, ib.out_val, ib.data_out}, {1'b1, 1'b0, 24'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    run3(16);
    wait_empty();

    // back-to-back results: one per IN_CH+3 cycles
    fill_rand();
    run3(16);
    first_cyc = acc_cyc - 2;
    for (int r = 0; r < 2; r++) begin
      fill_rand();
      beat(1, 1'b1, 1'b0, 16);
      chk("b2b_period", acc_cyc - first_cyc, 6);
      first_cyc = acc_cyc;
      beat(1, 1'b0, 1'b0, 16);
      beat(1, 1'b0, 1'b1, 16);
    end
    wait_empty();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
